sensor_input_conditioner: RTL and testbench
===========================================

# sensor_input_conditioner

Front-end stage of the irrigation controller: takes the six raw sensor inputs (three tank-level indicators, soil humidity, air humidity, temperature), synchronises them into the `clk` domain, debounces each one independently, and presents stable levels to the rule logic that drives the error, alarm, valve, irrigation and display paths. It also watches the three stable level indicators for a physically impossible combination. If that combination persists, it raises a sticky sensor-fault flag. The flag stays set until the operator clears it.

## Interface
- `DEBOUNCE_TICKS`, 4: consecutive disagreeing sample ticks needed before a channel's stable value flips; legal range ≥2.
- `FAULT_TICKS`, 8: consecutive ticks of an impossible level combination needed to latch the fault; legal range ≥2.

- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sample_tick_i` input 1: one-cycle sample enable; debounce and fault FSM advance only on ticks.
- `raw_i` input 6: raw sensors, bit order {temperature, air_humidity, soil_humidity, low_level, middle_level, high_level} (bit 0 = high_level).
- `clear_i` input 1: fault clear request; level-sensitive, not tick-gated.
- `stable_o` output 6: debounced levels, same bit order as `raw_i`.
- `changed_o` output 1: one-cycle pulse whenever any `stable_o` bit updates.
- `suspect_o` output 1: fault FSM is in SUSPECT.
- `fault_o` output 1: fault FSM is in FAULT.

## Operation
- **Synchroniser.** Each `raw_i` bit passes through two flops (`s1`, then `s2`). Both flops reset to 0.
- **Debounce, per channel.**
  - State: counter `cnt` of width $clog2(DEBOUNCE_TICKS) and register `stable`.
  - On a tick with `s2 != stable`: if `cnt == DEBOUNCE_TICKS-1`, set `stable <= s2` and `cnt <= 0`; otherwise `cnt++`.
  - On a tick with `s2 == stable`: `cnt <= 0`.
  - On a non-tick cycle: hold.
  - Channels are fully independent; several may flip on the same edge.
- **changed_o.** Registered. It is high in the cycle following any edge where at least one `stable` bit flipped, and low otherwise. Simultaneous flips produce a single pulse.
- **Level plausibility.**
  - `invalid = (high & ~middle) | (middle & ~low)`, computed from `stable_o`.
  - The FSM uses a counter `fcnt`.
- **Fault FSM states:** OK, SUSPECT, FAULT.
  - OK: on a tick with `invalid`, go to SUSPECT with `fcnt <= 1`.
  - SUSPECT, on a tick:
    - `!invalid`: go to OK with `fcnt <= 0`.
    - `invalid` and `fcnt == FAULT_TICKS-1`: go to FAULT.
    - Otherwise: `fcnt++`.
  - FAULT: sticky. In any cycle (tick or not) where `clear_i & !invalid`, go to OK with `fcnt <= 0`. `clear_i` while `invalid` is ignored, so the state stays FAULT.
  - `clear_i` has no effect in OK or SUSPECT.
- **Outputs:** `suspect_o` and `fault_o` are decoded from registered state. They are never high together.

## Timing
- **Reset values:** while `rst_n` is low, all of the following are 0: `stable_o`, `changed_o`, `suspect_o`, `fault_o`, every `cnt`, `fcnt`, both synchroniser stages. The FSM is in OK.
- **Reset mid-debounce or in FAULT:** reset acts immediately and asynchronously, discarding all progress. After release, no output moves until an input disagrees for a full debounce window.
- **Debounce latency** with `sample_tick_i` tied high: `stable_o` changes on the (2+DEBOUNCE_TICKS)-th rising edge after the raw change is set up. With the default of 4, that is edge 6. `changed_o` is high during the cycle after edge 6.
- **Sparse ticks:** latency is 2 edges plus DEBOUNCE_TICKS ticks. A tick in the same cycle the synchroniser output changes counts only if it occurs after `s2` has changed.
- **Glitches:** a glitch shorter than DEBOUNCE_TICKS consecutive ticks never reaches `stable_o`. A single agreeing tick restarts that channel's count.
- **Fault latency:** with ticks every cycle, `fault_o` rises FAULT_TICKS edges after `invalid` first becomes true. `suspect_o` rises 1 edge after.
- **Clear latency:** FAULT→OK takes 1 edge after `clear_i` is sampled high with levels valid.
- **Simultaneous events:** a `stable` flip that makes the combination valid, on the same edge as `clear_i`, does not clear the fault that cycle. The FSM sees the pre-flip `invalid` value, so `clear_i` must still be high on the next cycle.

## Test plan
- **Reset:** hold `rst_n`=0, toggle all `raw_i` → every output stays 0. Release, hold `raw_i`=0 → no `changed_o` pulse ever.
- **Debounce latency:** tick tied 1, defaults, `raw_i` 0→6'b000111 at edge 0 → `stable_o`=6'b000111 at edge 6. `changed_o`=1 for exactly one cycle; `fault_o` stays 0.
- **Glitch rejection:** pulse bit 5 high for 3 cycles, then low → `stable_o[5]` stays 0 and no `changed_o`. A 4-tick pulse (after 2 sync cycles) → bit 5 sets.
- **Sparse ticks:** tick every 5th cycle, bit 3 raised → `stable_o[3]` flips on the 4th tick after `s2` changes, not earlier.
- **Fault latch and clear:** set high=1, middle=0, low=1 → `suspect_o` asserts, then `fault_o`=1 after 8 ticks. `clear_i` pulse while still invalid → stays FAULT. Fix middle=1 and apply `clear_i` → OK next edge.
- **Suspect abort:** invalid for 5 ticks, then valid → `suspect_o` falls, `fault_o` never asserts. A further invalid burst restarts `fcnt` from 1.

Source files
------------

// File: rtl/sensor_input_conditioner.sv
// Sensor front end: two-flop sync, per-channel debounce,
// and a sticky fault latch for impossible tank-level combinations.
module sensor_input_conditioner #(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int FAULT_TICKS    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_tick_i,
    input  logic [5:0] raw_i,
    input  logic       clear_i,
    output logic [5:0] stable_o,
    output logic       changed_o,
    output logic       suspect_o,
    output logic       fault_o
);

    localparam int CW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int FW = (FAULT_TICKS > 1) ? $clog2(FAULT_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FAULT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_OK,
        ST_SUSPECT,
        ST_FAULT
    } state_t;

    logic [5:0]    s1_q;
    logic [5:0]    s2_q;
    logic [5:0]    stable_q;
    logic [5:0]    stable_d;
    logic [CW-1:0] cnt_q [6];
    logic [CW-1:0] cnt_d [6];
    logic          changed_q;
    logic          any_flip;

    state_t        state_q;
    state_t        state_d;
    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;
    logic          invalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        any_flip = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_tick_i) begin
                if (s2_q[i] != stable_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        stable_d[i] = s2_q[i];
                        cnt_d[i]    = '0;
                        any_flip    = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q  <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q  <= stable_d;
            changed_q <= any_flip;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Uses the registered levels, so a flip and a clear on the same edge
    // still see the pre-flip combination.
    assign invalid = (stable_q[0] & ~stable_q[1])
                   | (stable_q[1] & ~stable_q[2]);

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_OK: begin
                if (sample_tick_i && invalid) begin
                    state_d = ST_SUSPECT;
                    fcnt_d  = FW'(1);
                end
            end
            ST_SUSPECT: begin
                if (sample_tick_i) begin
                    if (!invalid) begin
                        state_d = ST_OK;
                        fcnt_d  = '0;
                    end else if (fcnt_q == FCNT_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (clear_i && !invalid) begin
                    state_d = ST_OK;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_OK;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign stable_o  = stable_q;
    assign changed_o = changed_q;
    assign suspect_o = (state_q == ST_SUSPECT);
    assign fault_o   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: directed literal checks
// plus random stimulus compared every cycle to a behavioural model.
module tb_sensor_input_conditioner;

    localparam int DT = 4;
    localparam int FT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [5:0] raw = '0;
    logic       clear = 1'b0;
    logic [5:0] stable_o;
    logic       changed_o;
    logic       suspect_o;
    logic       fault_o;

    int checks = 0;
    int errors = 0;

    sensor_input_conditioner #(
        .DEBOUNCE_TICKS(DT),
        .FAULT_TICKS(FT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_tick_i(tick),
        .raw_i(raw),
        .clear_i(clear),
        .stable_o(stable_o),
        .changed_o(changed_o),
        .suspect_o(suspect_o),
        .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: delayed raw history, disagreement run lengths,
    // and a run of consecutive invalid ticks with a sticky fault bit.
    logic [5:0] m_d1, m_s2, m_stable;
    int         m_dis [6];
    bit         m_chg;
    int         m_run;
    bit         m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '0; m_s2 = '0; m_stable = '0;
            foreach (m_dis[i]) m_dis[i] = 0;
            m_chg = 0; m_run = 0; m_fault = 0;
        end else begin
            bit inv;
            logic [5:0] nxt;
            inv = (m_stable[0] && !m_stable[1]) || (m_stable[1] && !m_stable[2]);
            if (m_fault) begin
                if (clear && !inv) begin
                    m_fault = 0;
                    m_run = 0;
                end
            end else if (tick) begin
                m_run = inv ? m_run + 1 : 0;
                if (m_run == FT) m_fault = 1;
            end
            nxt = m_stable;
            if (tick) begin
                for (int i = 0; i < 6; i++) begin
                    if (m_s2[i] != m_stable[i]) begin
                        m_dis[i]++;
                        if (m_dis[i] == DT) begin
                            nxt[i] = m_s2[i];
                            m_dis[i] = 0;
                        end
                    end else begin
                        m_dis[i] = 0;
                    end
                end
            end
            m_chg = (nxt != m_stable);
            m_stable = nxt;
            m_s2 = m_d1;
            m_d1 = raw;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_stable", 32'(stable_o), 32'(m_stable));
        chk("model_changed", 32'(changed_o), 32'(m_chg));
        chk("model_suspect", 32'(suspect_o), 32'(!m_fault && m_run > 0));
        chk("model_fault", 32'(fault_o), 32'(m_fault));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        bit seen, seen_f;
        int t_s, t_f, chg_cnt;

        // Reset holds everything at zero while inputs toggle
        rst_n = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            raw = 6'(i * 11 + 5);
            step();
            chk("rst_outputs", 32'({stable_o, changed_o, suspect_o, fault_o}), 32'd0);
        end
        raw = '0;
        step();
        rst_n = 1'b1;
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (changed_o) chg_cnt++;
        end
        chk("idle_no_change", 32'(chg_cnt), 32'd0);

        // Debounce latency with tick tied high
        raw = 6'b000111;
        step(5);
        chk("lat_edge5", 32'(stable_o), 32'h00);
        step();
        chk("lat_edge6", 32'(stable_o), 32'h07);
        chk("lat_chg_hi", 32'(changed_o), 32'd1);
        step();
        chk("lat_chg_lo", 32'(changed_o), 32'd0);
        chk("lat_nofault", 32'(fault_o), 32'd0);

        // Three-cycle glitch is rejected
        raw = 6'b100111;
        step(3);
        raw = 6'b000111;
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (changed_o) chg_cnt++;
        end
        chk("glitch_bit5", 32'(stable_o[5]), 32'd0);
        chk("glitch_nochg", 32'(chg_cnt), 32'd0);

        // Four-cycle pulse gets through
        raw = 6'b100111;
        step(4);
        raw = 6'b000111;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (stable_o[5]) seen = 1;
        end
        chk("pulse4_bit5", 32'(seen), 32'd1);
        step(12);
        chk("pulse4_back", 32'(stable_o), 32'h07);

        // Sparse ticks: every fifth cycle, flip on the fourth tick
        raw = 6'b001111;
        for (int i = 1; i <= 20; i++) begin
            tick = (i % 5 == 0);
            step();
            tick = 1'b0;
            if (i == 19) chk("sparse_tick3", 32'(stable_o[3]), 32'd0);
            if (i == 20) chk("sparse_tick4", 32'(stable_o[3]), 32'd1);
        end
        tick = 1'b1;
        raw = 6'b000111;
        step(8);

        // Fault latch: high=1, middle=0, low=1
        raw = 6'b000101;
        seen = 0; seen_f = 0; t_s = 0; t_f = 0;
        for (int i = 0; i < 40 && !seen_f; i++) begin
            step();
            if (suspect_o && !seen) begin seen = 1; t_s = i; end
            if (fault_o) begin seen_f = 1; t_f = i; end
        end
        chk("fault_reached", 32'(seen_f), 32'd1);
        chk("fault_latency", 32'(t_f - t_s), 32'(FT - 1));
        clear = 1'b1;
        step(2);
        clear = 1'b0;
        chk("clear_invalid", 32'(fault_o), 32'd1);
        raw = 6'b000111;
        clear = 1'b1;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (!fault_o) seen = 1;
        end
        clear = 1'b0;
        chk("clear_ok", 32'(seen), 32'd1);
        chk("clear_nosus", 32'(suspect_o), 32'd0);
        step(4);

        // Suspect abort: five invalid ticks then valid again
        raw = 6'b000101;
        step(5);
        raw = 6'b000111;
        seen = 0; seen_f = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (suspect_o) seen = 1;
            if (fault_o) seen_f = 1;
        end
        chk("abort_suspect", 32'(seen), 32'd1);
        chk("abort_nofault", 32'(seen_f), 32'd0);
        chk("abort_sus_low", 32'(suspect_o), 32'd0);

        // Random phase with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
            tick = ($urandom_range(0, 2) != 0);
            clear = ($urandom_range(0, 7) == 0);
            if (i == 1500) rst_n = 1'b0;
            if (i == 1503) rst_n = 1'b1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
